shift_reg_piso: RTL and testbench

- Parallel-in, serial-out shift register. It is the transmit end of the serial bit stream that the team's serial-in registers capture.
- Accepts one WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock cycle, with valid and last framing.
- Sits between the register/datapath side and any serial link built from the team's D flip-flop stages.

---
 rtl/shift_reg_piso.sv | 134 +++++++++++++
 tb/tb_shift_reg_piso.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_piso.sv
// shift_reg_piso: parallel-in serial-out shifter with valid/ready load and valid/last framing.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module shift_reg_piso #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             head_bit;
  logic [WIDTH-1:0] shifted;

  // The head is the bit on the wire; shifting moves the next bit into it.
  always_comb begin
    if (MSB_FIRST) begin
      head_bit = shift_q[WIDTH-1];
      shifted  = {shift_q[WIDTH-2:0], 1'b0};
    end else begin
      head_bit = shift_q[0];
      shifted  = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shift_d  = load_data;
          cnt_d    = '0;
`ifdef PISO_PARITY_EN
          parity_d = ^load_data;
`endif
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          shift_d = shifted;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
`ifdef PISO_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (ser_en) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    load_ready = (state_q == IDLE);
    ser_valid  = 1'b0;
    ser_out    = 1'b0;
    ser_last   = 1'b0;
    if (state_q == SHIFT) begin
      ser_valid = 1'b1;
      ser_out   = head_bit;
`ifndef PISO_PARITY_EN
      ser_last  = (cnt_q == LAST_CNT);
`endif
    end
`ifdef PISO_PARITY_EN
    if (state_q == PARITY) begin
      ser_valid = 1'b1;
      ser_out   = parity_q;
      ser_last  = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_shift_reg_piso.sv
// Bench for shift_reg_piso: two instances (MSB-first and LSB-first) checked every cycle
// against a frame-list model, plus directed literal frames and randomized traffic.
module tb_shift_reg_piso;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = W + 1;
`else
  localparam int FRAME_LEN = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         loadValid = 1'b0;
  logic         serEn = 1'b0;
  logic [W-1:0] loadData = '0;

  logic loadReadyM, serOutM, serValidM, serLastM;
  logic loadReadyL, serOutL, serValidL, serLastL;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_reg_piso #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (loadValid),
    .load_ready (loadReadyM),
    .load_data  (loadData),
    .ser_en     (serEn),
    .ser_out    (serOutM),
    .ser_valid  (serValidM),
    .ser_last   (serLastM)
  );

  shift_reg_piso #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (loadValid),
    .load_ready (loadReadyL),
    .load_data  (loadData),
    .ser_en     (serEn),
    .ser_out    (serOutL),
    .ser_valid  (serValidL),
    .ser_last   (serLastL)
  );

  // Transmission order of a word: index 0 goes out first, index 8 is the parity bit.
  function automatic logic [8:0] frameOf(input logic [7:0] w, input bit msb);
    logic [8:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[i] = msb ? w[7-i] : w[i];
    f[8] = ^w;
    return f;
  endfunction

  // Model: index 0 is the MSB-first instance, index 1 the LSB-first one.
  bit         busy [2];
  int         idx  [2];
  logic [8:0] frm  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        busy[i] <= 1'b0;
        idx[i]  <= 0;
        frm[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!busy[i]) begin
          if (loadValid) begin
            busy[i] <= 1'b1;
            idx[i]  <= 0;
            frm[i]  <= frameOf(loadData, (i == 0));
          end
        end else if (serEn) begin
          if (idx[i] == FRAME_LEN - 1) busy[i] <= 1'b0;
          else idx[i] <= idx[i] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("M.load_ready", 9'(loadReadyM), 9'(!busy[0]));
    checkOutput("M.ser_valid",  9'(serValidM),  9'(busy[0]));
    checkOutput("M.ser_out",    9'(serOutM),    9'(busy[0] ? frm[0][idx[0]] : 1'b0));
    checkOutput("M.ser_last",   9'(serLastM),   9'(busy[0] && idx[0] == FRAME_LEN - 1));
    checkOutput("L.load_ready", 9'(loadReadyL), 9'(!busy[1]));
    checkOutput("L.ser_valid",  9'(serValidL),  9'(busy[1]));
    checkOutput("L.ser_out",    9'(serOutL),    9'(busy[1] ? frm[1][idx[1]] : 1'b0));
    checkOutput("L.ser_last",   9'(serLastL),   9'(busy[1] && idx[1] == FRAME_LEN - 1));
  end

  logic [8:0] collM, collL;
  int         nColl, nLast;
  logic       lastOnFinal, rdyM;

  // Drives one cycle of inputs; records a bit whenever it is consumed by an enabled edge.
  task automatic applyStimulus(input logic lv, input logic [7:0] ld, input logic en);
    loadValid = lv;
    loadData  = ld;
    serEn     = en;
    @(negedge clk);
    rdyM = loadReadyM;
    if (en && serValidM && nColl < FRAME_LEN) begin
      collM = {collM[7:0], serOutM};
      collL = {collL[7:0], serOutL};
      nColl++;
      if (serLastM) nLast++;
      lastOnFinal = serLastM;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input logic [7:0] w);
    int n;
    n = 0;
    while (busy[0] && n < 100) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      n++;
    end
    applyStimulus(1'b1, w, 1'b1);
  endtask

  task automatic collectFrame(input int mode, input logic lv, input logic [7:0] ld);
    int c;
    c = 0;
    nColl = 0;
    nLast = 0;
    collM = '0;
    collL = '0;
    lastOnFinal = 1'b0;
    while (nColl < FRAME_LEN && c < 100) begin
      applyStimulus(lv, ld, (mode == 0) ? 1'b1 : (c % 3 == 0));
      c++;
    end
    checks++;
    if (nColl < FRAME_LEN) begin
      failures++;
      $display("[TB] FAIL collect_timeout actual=%0d bits required=%0d bits", nColl, FRAME_LEN);
    end
  endtask

  task automatic checkFrame(input string name, input logic [7:0] expM, input logic [7:0] expL);
    checkOutput({name, " M bits"}, 9'(collM[FRAME_LEN-1 -: 8]), 9'(expM));
    checkOutput({name, " L bits"}, 9'(collL[FRAME_LEN-1 -: 8]), 9'(expL));
    checkOutput({name, " last count"}, 9'(nLast), 9'd1);
    checkOutput({name, " last on final"}, 9'(lastOnFinal), 9'd1);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    checkOutput("reset ser_valid", 9'(serValidM | serValidL), 9'd0);
    checkOutput("reset ser_out",   9'(serOutM | serOutL), 9'd0);
    checkOutput("reset ser_last",  9'(serLastM | serLastL), 9'd0);
    checkOutput("reset load_ready", 9'(loadReadyM & loadReadyL), 9'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    checkOutput("por ser_out",    9'(serOutM | serOutL), 9'd0);
    checkOutput("por ser_valid",  9'(serValidM | serValidL), 9'd0);
    checkOutput("por ser_last",   9'(serLastM | serLastL), 9'd0);
    checkOutput("por load_ready", 9'(loadReadyM & loadReadyL), 9'd1);
    @(posedge clk);
    #1;

    loadWord(8'hA5);
    collectFrame(0, 1'b0, 8'h00);
    checkFrame("A5", 8'hA5, 8'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("A5 ready after frame", 9'(rdyM), 9'd1);

    loadWord(8'h01);
    collectFrame(0, 1'b1, 8'hFF);
    checkFrame("01", 8'h01, 8'h80);
    applyStimulus(1'b1, 8'hFF, 1'b1);
    checkOutput("FF ready before accept", 9'(rdyM), 9'd1);
    collectFrame(0, 1'b0, 8'h00);
    checkFrame("FF held", 8'hFF, 8'hFF);

    loadWord(8'hC3);
    collectFrame(1, 1'b0, 8'h00);
    checkFrame("C3 gapped", 8'hC3, 8'hC3);

    loadWord(8'hFF);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    pulseReset();
    loadWord(8'h0F);
    collectFrame(0, 1'b0, 8'h00);
    checkFrame("0F after reset", 8'h0F, 8'hF0);

`ifdef PISO_PARITY_EN
    loadWord(8'h07);
    collectFrame(0, 1'b0, 8'h00);
    checkFrame("07 parity", 8'h07, 8'hE0);
    checkOutput("07 parity bit", 9'(collM[0]), 9'd1);
    loadWord(8'h03);
    collectFrame(0, 1'b0, 8'h00);
    checkFrame("03 parity", 8'h03, 8'hC0);
    checkOutput("03 parity bit", 9'(collM[0]), 9'd0);
`endif

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) pulseReset();
      else applyStimulus($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
